// File: rtl/cle_pkg.sv
// Shared constants and types for the connected-label engine and its mask exporter.
// Mask bytes follow the binary image ROM layout: byte {x, y[4:3]}, MSB = pixel with y[2:0]=0.
package cle_pkg;

    localparam int IMG_DIM = 32;
    localparam int PIX_AW  = 10;  // {x[4:0], y[4:0]}
    localparam int BYTE_AW = 7;   // {x[4:0], y[4:3]}

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit position inside a mask byte for a pixel with the given y[2:0].
    function automatic logic [2:0] mask_bit_pos(input logic [2:0] y_lo);
        return 3'd7 - y_lo;
    endfunction

endpackage

// File: rtl/cle_bit_packer.sv
// Serial-in byte shifter: collects one hit bit per valid pixel, MSB first, and
// emits a single-cycle active-low write of each completed byte in ascending order.
module cle_bit_packer
    import cle_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               bit_vld,
    input  logic               bit_in,
    output logic [BYTE_AW-1:0] mask_a,
    output logic [7:0]         mask_d,
    output logic               mask_wen
);

    logic [6:0]         shift_q, shift_d;
    logic [2:0]         idx_q, idx_d;
    logic [BYTE_AW-1:0] byte_q, byte_d;
    logic [BYTE_AW-1:0] mask_a_q, mask_a_d;
    logic [7:0]         mask_d_q, mask_d_d;
    logic               wen_q, wen_d;

    always_comb begin
        shift_d  = shift_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        mask_a_d = mask_a_q;
        mask_d_d = mask_d_q;
        wen_d    = 1'b1;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
            byte_d  = '0;
        end else if (bit_vld) begin
            shift_d = {shift_q[5:0], bit_in};
            idx_d   = idx_q + 3'd1;
            // Eighth bit completes the byte; the first-shifted bit lands in the MSB.
            if (idx_q == 3'd7) begin
                mask_d_d = {shift_q, bit_in};
                mask_a_d = byte_q;
                wen_d    = 1'b0;
                byte_d   = byte_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            mask_a_q <= '0;
            mask_d_q <= '0;
            wen_q    <= 1'b1;
        end else begin
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            mask_a_q <= mask_a_d;
            mask_d_q <= mask_d_d;
            wen_q    <= wen_d;
        end
    end

    assign mask_a   = mask_a_q;
    assign mask_d   = mask_d_q;
    assign mask_wen = wen_q;

endmodule

// File: rtl/cle_mask_packer.sv
// Reads the 32x32 label map back in raster order (y fastest), selects pixels by label
// and writes a packed 1-bit mask plus the selected pixel area.
module cle_mask_packer #(
    parameter int IMG_DIM = 32,
    parameter int LBL_W   = 8,
    parameter int AREA_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LBL_W-1:0]  sel_label,
    output logic [9:0]        sram_a,
    input  logic [LBL_W-1:0]  sram_q,
    output logic [6:0]        mask_a,
    output logic [7:0]        mask_d,
    output logic              mask_wen,
    output logic              busy,
    output logic              done,
    output logic [AREA_W-1:0] area
);
    import cle_pkg::*;

    state_t            state_q, state_d;
    logic [PIX_AW-1:0] pix_q, pix_d;
    logic [LBL_W-1:0]  sel_q, sel_d;
    logic [AREA_W-1:0] area_q, area_d;
    logic              rd_vld_q, rd_vld_d;
    logic              drain_q, drain_d;
    logic              hit;
    logic              pk_clr;

    // Read data for the address issued in a RUN cycle is valid one cycle later.
    assign hit = rd_vld_q && ((sel_q == '0) ? (sram_q != '0) : (sram_q == sel_q));

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        sel_d    = sel_q;
        area_d   = area_q;
        drain_d  = drain_q;
        rd_vld_d = (state_q == RUN);
        pk_clr   = 1'b0;
        if (hit) area_d = area_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sel_d   = sel_label;
                    area_d  = '0;
                    pix_d   = '0;
                    pk_clr  = 1'b1;
                end
            end
            RUN: begin
                if (pix_q == '1) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            sel_q    <= '0;
            area_q   <= '0;
            rd_vld_q <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            sel_q    <= sel_d;
            area_q   <= area_d;
            rd_vld_q <= rd_vld_d;
            drain_q  <= drain_d;
        end
    end

    cle_bit_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clr      (pk_clr),
        .bit_vld  (rd_vld_q),
        .bit_in   (hit),
        .mask_a   (mask_a),
        .mask_d   (mask_d),
        .mask_wen (mask_wen)
    );

    assign sram_a = pix_q;
    assign busy   = (state_q == RUN) || (state_q == DRAIN);
    assign done   = (state_q == DONE);
    assign area   = area_q;

endmodule

// File: doc/cle_mask_packer.md
Name: cle_mask_packer

Overview:
- Reads back a finished 32x32 label map from the label SRAM, one 8-bit label per pixel at address {x,y}.
- Produces a packed 1-bit mask in the same byte format as the binary image ROM:
  - 128 bytes, byte address {x, y[4:3]};
  - MSB holds the pixel with y[2:0]=0.
- Pixel is set when its label equals a selected label, or, with sel_label=0, when its label is any non-zero value.
- Also reports the pixel area of the selection. Sits downstream of the labeling engine to export per-component masks.

Parameters:
- IMG_DIM, 32, image width/height in pixels (fixed; address math assumes 32).
- LBL_W, 8, label and SRAM data width.
- AREA_W, 11, area counter width (max 1024).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a pass; sampled only in IDLE.
- sel_label  input  8  label to extract; 0 = all non-zero labels. Latched at start.
- sram_a  output  10  label SRAM read address {x[4:0], y[4:0]}.
- sram_q  input  8  label SRAM read data; synchronous read with 1-cycle latency.
- mask_a  output  7  mask memory byte address {x, y[4:3]}.
- mask_d  output  8  packed mask byte.
- mask_wen  output  1  mask memory write enable, active-low.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the pass is complete.
- area  output  11  count of selected pixels. Valid from done; held until the next start.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs take their reset values:
  - sram_a=0, mask_a=0, mask_d=0, mask_wen=1;
  - busy=0, done=0, area=0;
  - internal pixel counter and shift register cleared.
- Reset during a pass aborts it immediately. No partial write completes after reset is asserted.
- States:
  - IDLE: start=1 moves to RUN. sel_label is latched, area cleared, pixel counter=0.
  - RUN: sram_a = pixel counter, advancing 0..1023 in raster order (y fastest). After issuing 1023, go to DRAIN.
  - DRAIN: waits for the last read data and the last byte write (2 cycles), then goes to DONE.
  - DONE: done=1 for one cycle, busy falls, return to IDLE.
- Read pipeline:
  - Address k is driven during cycle k+1 after start acceptance.
  - Its data is sampled at the rising edge ending cycle k+2.
- Compare rule:
  - hit = (sel_label==0) ? (sram_q!=0) : (sram_q==sel_label).
  - Full 8-bit compare, no masking.
- Packing:
  - Each hit bit is shifted into an 8-bit register, MSB first.
  - On the sample with k[2:0]=7: mask_d={shift[6:0],hit}, mask_a=k[9:3], mask_wen=0 for exactly one cycle. mask_wen=1 otherwise.
  - Exactly 128 writes per pass, in ascending mask_a order.
- area increments by 1 per hit. No overflow is possible (max 1024).
- Timing: the last write is visible in the cycle after the sample of pixel 1023. done is asserted on the 1026th rising edge after the edge that accepted start.
- start while busy or during DONE: ignored. sel_label changes during a pass: ignored.
- The block never writes the label SRAM. sram_a holds its last value outside RUN.

Decomposition:
- Shared package cle_pkg holds:
  - IMG_DIM, the pixel/byte address widths;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the ROM/mask bit-order convention (MSB = y[2:0]=0), shared with the labeling engine.
- One sub-module, cle_bit_packer: serial-in byte shifter with bit index and byte-complete strobe, producing mask_a/mask_d/mask_wen.
- FSM, address counter, compare and area counter stay in the top.

Test Plan:
- All-zero SRAM, sel_label=0 → 128 writes of 0x00 at mask_a 0..127; area=0; done on the 1026th edge after start.
- SRAM label 5 at exactly (0,0) and (31,31), sel_label=5 → byte 0 = 0x80, byte 127 = 0x01, all others 0x00; area=2.
- Two components (labels 2 and 7, 40 and 60 pixels), sel_label=7 → mask matches only label-7 pixels; area=60. Rerun with sel_label=0 → union mask; area=100.
- start pulsed again mid-RUN with a different sel_label → no restart, result uses the first label, single done pulse.
- reset asserted after 300 cycles of RUN → all outputs immediately at reset values, no further mask_wen=0. A fresh start after release completes normally with the correct mask.
- Full row y=0..31 at x=10 set to label 1 → bytes 40..43 = 0xFF, others 0x00; area=32.
